uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx_fifo_if.sv | 25 ++
 rtl/baud_tick_gen.sv | 32 +++
 rtl/uart_tx_fifo.sv | 111 +++++++++++
 tb/tb_uart_tx_fifo.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared UART transmitter types and helpers.
//   uart_tx_state_t : frame sequencer states
//   calc_div()      : clk cycles per serial bit (integer truncation)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
`timescale 1ns/1ps
// Pop-side handshake between the UART transmitter and its upstream FIFO.
//   fifo_empty : FIFO has nothing to send
//   fifo_rdata : head-of-FIFO data, valid in the cycle fifo_rd_en is high
//   fifo_rd_en : pop strobe from the transmitter
// master = transmitter (consumer), slave = FIFO (provider).
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_rd_en;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        output fifo_rd_en
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        input  fifo_rd_en
    );
endinterface

// File: rtl/baud_tick_gen.sv
`timescale 1ns/1ps
// Baud counter: counts 0..DIV-1 and flags the last cycle of every bit period.
//   clk, reset : clock, async active-high reset
//   clear      : hold the counter at 0 (idle line)
//   tick       : high while the count sits at DIV-1
module baud_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Wraps at DIV-1 so consecutive bit periods need no restart.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == LAST) & ~clear;

endmodule

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// UART transmitter that pulls bytes straight from an upstream FIFO.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, one stop bit (1).
//   clk, reset : clock, async active-high reset
//   fifo       : pop handshake to the upstream FIFO (master side)
//   tx         : serial line, idle high, registered
//   busy       : frame in progress
//   tx_done    : high on the last cycle of the stop bit
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_fifo_if.master fifo,
    output logic           tx,
    output logic           busy,
    output logic           tx_done
);
    localparam int unsigned DIV       = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 2");
    end

    uart_tx_state_t        state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  baud_clear;
    logic                  baud_tick;

    assign shift_next = shift_reg >> 1;

    // Counter is parked at 0 while idle, so each frame starts on a fresh period.
    assign baud_clear = (state == IDLE);

    baud_tick_gen #(
        .DIV (DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .tick  (baud_tick)
    );

    // Pop only from IDLE; gated by reset so it drops the instant reset rises.
    assign fifo.fifo_rd_en = (state == IDLE) & ~fifo.fifo_empty & ~reset;

    // Last stop-bit cycle; both terms come straight from flops.
    assign tx_done = (state == STOP) & baud_tick;

    // Frame sequencer with registered tx/busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo.fifo_rd_en) begin
                        shift_reg <= fifo.fifo_rdata;
                        bit_cnt   <= '0;
                        tx        <= 1'b0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            tx      <= shift_next[0];
                        end
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo: a queue-backed FIFO model feeds the DUT and a
// line-sampling receiver model reconstructs each frame from tx.
module tb_uart_tx_fifo;
    localparam int CLK_FREQ  = 1_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int DW        = 8;
    localparam int DIV       = CLK_FREQ / BAUD_RATE;
    localparam int FRAME     = (DW + 2) * DIV;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic tx, busy, tx_done;

    uart_tx_fifo_if #(.DATA_WIDTH(DW)) fifo ();

    uart_tx_fifo #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .fifo    (fifo),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    int          vectors    = 0;
    int          miscompares = 0;
    logic [7:0]  src_q[$];
    bit          scramble   = 1'b0;
    bit          rel_req    = 1'b0;
    int          cyc_no     = 0;
    int          last_pop   = 0;
    logic        s_tx, s_busy, s_done, s_rd;

    // One clock cycle: drive FIFO model at negedge, sample outputs 1ns later.
    task automatic cyc();
        logic [7:0] tmp;
        @(negedge clk);
        if (rel_req) begin
            reset   = 1'b0;
            rel_req = 1'b0;
        end
        if (scramble) begin
            fifo.fifo_empty = 1'($urandom_range(0, 1));
            fifo.fifo_rdata = 8'h3C;
        end else if (src_q.size() > 0) begin
            fifo.fifo_empty = 1'b0;
            fifo.fifo_rdata = src_q[0];
        end else begin
            fifo.fifo_empty = 1'b1;
            fifo.fifo_rdata = 8'($urandom);
        end
        #1;
        s_tx   = tx;
        s_busy = busy;
        s_done = tx_done;
        s_rd   = fifo.fifo_rd_en;
        cyc_no++;
        if (s_rd) begin
            last_pop = cyc_no;
            if (!scramble && src_q.size() > 0) tmp = src_q.pop_front();
        end
    endtask

    task automatic wait_pop(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            cyc();
            if (s_rd) ok = 1'b1;
        end
    endtask

    // Receiver model: samples FRAME cycles after a pop, bit value at mid-period.
    task automatic recv_frame(output logic [7:0] data, output logic start_b,
                              output logic stop_b, output int glitches,
                              output int done_cnt, output int done_at,
                              output int busy_cnt, output int pops);
        logic slot_val;
        int   slot;
        data = '0; start_b = 1'b1; stop_b = 1'b0; slot_val = 1'b0;
        glitches = 0; done_cnt = 0; done_at = -1; busy_cnt = 0; pops = 0;
        for (int k = 0; k < FRAME; k++) begin
            cyc();
            if (k % DIV == 0) slot_val = s_tx;
            else if (s_tx !== slot_val) glitches++;
            if (k % DIV == DIV / 2) begin
                slot = k / DIV;
                if (slot == 0) start_b = s_tx;
                else if (slot == DW + 1) stop_b = s_tx;
                else data[slot-1] = s_tx;
            end
            if (s_done === 1'b1) begin
                done_cnt++;
                done_at = k + 1;
            end
            if (s_busy === 1'b1) busy_cnt++;
            if (s_rd === 1'b1) pops++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_q.push_back(8'h12);
        fifo.fifo_empty = 1'b0;
        fifo.fifo_rdata = 8'h12;
        #1;
        vectors++;
        if ({tx, busy, tx_done, fifo.fifo_rd_en} !== 4'b1000) begin
            miscompares++;
            $display("FAIL reset_async: {tx,busy,done,rd}=%b expected 1000",
                     {tx, busy, tx_done, fifo.fifo_rd_en});
        end
        for (int i = 0; i < 20; i++) begin
            cyc();
            vectors++;
            if ({s_tx, s_busy, s_done, s_rd} !== 4'b1000) begin
                miscompares++;
                $display("FAIL reset_hold cyc %0d: {tx,busy,done,rd}=%b expected 1000",
                         i, {s_tx, s_busy, s_done, s_rd});
            end
        end
        src_q.delete();
        rel_req = 1'b1;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 500; i++) begin
            cyc();
            vectors++;
            if ({s_tx, s_busy, s_done, s_rd} !== 4'b1000) begin
                miscompares++;
                $display("FAIL idle cyc %0d: {tx,busy,done,rd}=%b expected 1000",
                         i, {s_tx, s_busy, s_done, s_rd});
            end
        end
    endtask

    // Cycle-exact waveform of a single 0xA5 frame.
    task automatic test_single_byte();
        logic [7:0] b = 8'hA5;
        logic [3:0] exp;
        logic       exp_tx;
        int         slot;
        bit         ok;
        src_q.push_back(b);
        wait_pop(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_pop: no fifo_rd_en within 20 cycles, expected one");
        end
        for (int k = 1; k <= FRAME; k++) begin
            cyc();
            slot   = (k - 1) / DIV;
            exp_tx = (slot == 0) ? 1'b0 : (slot == DW + 1) ? 1'b1 : b[slot-1];
            exp    = {exp_tx, 1'b1, (k == FRAME), 1'b0};
            vectors++;
            if ({s_tx, s_busy, s_done, s_rd} !== exp) begin
                miscompares++;
                $display("FAIL single cyc %0d: {tx,busy,done,rd}=%b expected %b",
                         k, {s_tx, s_busy, s_done, s_rd}, exp);
            end
        end
        cyc();
        vectors++;
        if ({s_tx, s_busy, s_done, s_rd} !== 4'b1000) begin
            miscompares++;
            $display("FAIL single_after: {tx,busy,done,rd}=%b expected 1000",
                     {s_tx, s_busy, s_done, s_rd});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes[3] = '{8'h00, 8'hFF, 8'h55};
        logic [7:0] d;
        logic       st, sp;
        int         gl, dc, da, bc, pc, prev;
        bit         ok;
        for (int i = 0; i < 3; i++) src_q.push_back(bytes[i]);
        wait_pop(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_first_pop: no fifo_rd_en within 20 cycles");
        end
        prev = last_pop;
        for (int i = 0; i < 3; i++) begin
            recv_frame(d, st, sp, gl, dc, da, bc, pc);
            vectors++;
            if ({st, sp, d} !== {1'b0, 1'b1, bytes[i]}) begin
                miscompares++;
                $display("FAIL b2b_data[%0d]: start=%b stop=%b data=%h expected 0 1 %h",
                         i, st, sp, d, bytes[i]);
            end
            vectors++;
            if (gl != 0 || dc != 1 || da != FRAME || bc != FRAME || pc != 0) begin
                miscompares++;
                $display("FAIL b2b_timing[%0d]: glitch=%0d done=%0d@%0d busy=%0d pops=%0d expected 0 1@%0d %0d 0",
                         i, gl, dc, da, bc, pc, FRAME, FRAME);
            end
            cyc();
            if (i < 2) begin
                vectors++;
                if (!s_rd || (last_pop - prev) != FRAME + 1) begin
                    miscompares++;
                    $display("FAIL b2b_spacing[%0d]: rd=%b spacing=%0d expected 1 %0d",
                             i, s_rd, last_pop - prev, FRAME + 1);
                end
                prev = last_pop;
            end else begin
                vectors++;
                if ({s_tx, s_busy, s_rd} !== 3'b100) begin
                    miscompares++;
                    $display("FAIL b2b_end: {tx,busy,rd}=%b expected 100", {s_tx, s_busy, s_rd});
                end
            end
        end
    endtask

    // FIFO inputs wiggle during the frame; the frame must be unaffected.
    task automatic test_isolation();
        logic [7:0] d;
        logic       st, sp;
        int         gl, dc, da, bc, pc;
        bit         ok;
        src_q.push_back(8'h81);
        wait_pop(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL iso_pop: no fifo_rd_en within 20 cycles");
        end
        scramble = 1'b1;
        recv_frame(d, st, sp, gl, dc, da, bc, pc);
        scramble = 1'b0;
        vectors++;
        if ({st, sp, d} !== {1'b0, 1'b1, 8'h81} || pc != 0) begin
            miscompares++;
            $display("FAIL iso_data: start=%b stop=%b data=%h pops=%0d expected 0 1 81 0",
                     st, sp, d, pc);
        end
        cyc();
        vectors++;
        if ({s_tx, s_busy, s_rd} !== 3'b100) begin
            miscompares++;
            $display("FAIL iso_end: {tx,busy,rd}=%b expected 100", {s_tx, s_busy, s_rd});
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b1 = 8'($urandom);
        logic [7:0] b2 = 8'($urandom);
        logic [7:0] d;
        logic       st, sp;
        int         gl, dc, da, bc, pc;
        bit         ok;
        src_q.push_back(b1);
        wait_pop(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_mid_pop: no fifo_rd_en within 20 cycles");
        end
        for (int k = 1; k < 45; k++) cyc();
        src_q.push_back(b2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({tx, busy, tx_done, fifo.fifo_rd_en} !== 4'b1000) begin
            miscompares++;
            $display("FAIL rst_mid_async: {tx,busy,done,rd}=%b expected 1000",
                     {tx, busy, tx_done, fifo.fifo_rd_en});
        end
        for (int i = 0; i < 5; i++) begin
            cyc();
            vectors++;
            if ({s_tx, s_busy, s_done, s_rd} !== 4'b1000) begin
                miscompares++;
                $display("FAIL rst_mid_hold cyc %0d: {tx,busy,done,rd}=%b expected 1000",
                         i, {s_tx, s_busy, s_done, s_rd});
            end
        end
        rel_req = 1'b1;
        wait_pop(20, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rst_mid_resume: no fifo_rd_en within 20 cycles after release");
        end
        recv_frame(d, st, sp, gl, dc, da, bc, pc);
        vectors++;
        if ({st, sp, d} !== {1'b0, 1'b1, b2} || gl != 0 || dc != 1 || da != FRAME) begin
            miscompares++;
            $display("FAIL rst_mid_next: start=%b stop=%b data=%h glitch=%0d done=%0d@%0d expected 0 1 %h 0 1@%0d",
                     st, sp, d, gl, dc, da, b2, FRAME);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [7:0] b, d;
        logic       st, sp;
        int         gl, dc, da, bc, pc, prev, gap;
        bit         ok;
        prev = last_pop;
        for (int n = 0; n < 6; n++) begin
            b   = 8'($urandom);
            gap = int'($urandom_range(0, 15));
            repeat (gap) cyc();
            src_q.push_back(b);
            wait_pop(50, ok);
            vectors++;
            if (!ok || (last_pop - prev) < FRAME + 1) begin
                miscompares++;
                $display("FAIL rand_pop[%0d]: popped=%b spacing=%0d expected 1 >=%0d",
                         n, ok, last_pop - prev, FRAME + 1);
            end
            prev = last_pop;
            recv_frame(d, st, sp, gl, dc, da, bc, pc);
            vectors++;
            if ({st, sp, d} !== {1'b0, 1'b1, b} || gl != 0 || dc != 1 || da != FRAME ||
                bc != FRAME || pc != 0) begin
                miscompares++;
                $display("FAIL rand_frame[%0d]: start=%b stop=%b data=%h glitch=%0d done=%0d@%0d busy=%0d pops=%0d expected 0 1 %h 0 1@%0d %0d 0",
                         n, st, sp, d, gl, dc, da, bc, pc, b, FRAME, FRAME);
            end
        end
    endtask

    initial begin
        fifo.fifo_empty = 1'b1;
        fifo.fifo_rdata = '0;
        #2;
        test_reset();
        test_idle();
        test_single_byte();
        test_back_to_back();
        test_isolation();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
